// File: rtl/mc_controller.sv
// mc_controller: main sequencing FSM of the multicycle processor.
// Walks the shared datapath through fetch/decode/execute/memory/writeback
// and drives every mux select, write enable and the shared ALU function code.
module mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [2:0] alu_f,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t cur_state;
  state_t nxt_state;

  // Raw (ungated) Moore outputs; enables are masked while reset is held.
  logic       pc_write;
  logic       branch;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       done_raw;
  logic [2:0] rtype_alu;

  // State register; reset abandons any partial instruction and returns to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= FETCH;
    else        cur_state <= nxt_state;
  end

  // Next-state logic driven by the opcode held in IR.
  always_comb begin
    nxt_state = FETCH;
    case (cur_state)
      FETCH:   nxt_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_R:         nxt_state = RTYPEEX;
          OP_BEQ:       nxt_state = BEQEX;
          OP_ADDI:      nxt_state = ADDIEX;
          OP_J:         nxt_state = JEX;
          default:      nxt_state = FETCH;
        endcase
      end
      MEMADR:  nxt_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nxt_state = MEMWB;
      RTYPEEX: nxt_state = RTYPEWB;
      ADDIEX:  nxt_state = ADDIWB;
      default: nxt_state = FETCH;
    endcase
  end

  // R-type funct to ALU code; unrecognised functs fall back to add.
  always_comb begin
    rtype_alu = ALU_ADD;
    case (funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   rtype_alu = ALU_ADD;
    endcase
  end

  // Moore output decode per state; unlisted outputs stay at their defaults.
  always_comb begin
    iord          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    pc_write      = 1'b0;
    branch        = 1'b0;
    alu_f         = ALU_ADD;
    done_raw      = 1'b0;
    case (cur_state)
      FETCH: begin
        alu_src_b    = 2'b01;
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J: done_raw = 1'b0;
          default:                                   done_raw = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_f     = rtype_alu;
      end
      RTYPEWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_f     = ALU_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        done_raw  = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        done_raw = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write enables and the done pulse are forced low while reset is asserted;
  // zero feeds pc_en combinationally so a taken branch loads PC in BEQEX.
  assign mem_write  = rst_n & mem_write_raw;
  assign ir_write   = rst_n & ir_write_raw;
  assign reg_write  = rst_n & reg_write_raw;
  assign pc_en      = rst_n & (pc_write | (branch & zero));
  assign instr_done = rst_n & done_raw;
  assign state      = cur_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized self-checking bench for mc_controller.
// Each instruction is expanded into a list of named phases; expected outputs
// come from the per-phase control table and the opcode/funct rules.
module tb_mc_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, instr_done;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_f;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  string plan[$];

  logic [15:0] act;
  assign act = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, pc_src, pc_en, alu_f, instr_done};

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_en(pc_en), .alu_f(alu_f), .instr_done(instr_done), .state(state)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [3:0] state_of(input string ph);
    if (ph == "F" || ph == "RST") return 4'd0;
    if (ph == "D" || ph == "DU")  return 4'd1;
    if (ph == "MA")  return 4'd2;
    if (ph == "MR")  return 4'd3;
    if (ph == "MWB") return 4'd4;
    if (ph == "MW")  return 4'd5;
    if (ph == "RX")  return 4'd6;
    if (ph == "RW")  return 4'd7;
    if (ph == "BX")  return 4'd8;
    if (ph == "AX")  return 4'd9;
    if (ph == "AW")  return 4'd10;
    return 4'd11;
  endfunction

  function automatic logic [15:0] expect_out(input string ph, input logic [5:0] fn, input logic z);
    logic e_iord, e_mw, e_irw, e_rdst, e_m2r, e_rw, e_sa, e_pce, e_done;
    logic [1:0] e_sb, e_pcs;
    logic [2:0] e_f;
    e_iord = 0; e_mw = 0; e_irw = 0; e_rdst = 0; e_m2r = 0; e_rw = 0;
    e_sa = 0; e_pce = 0; e_done = 0; e_sb = 2'b00; e_pcs = 2'b00; e_f = 3'b010;
    if (ph == "RST") e_sb = 2'b01;
    else if (ph == "F") begin e_sb = 2'b01; e_irw = 1; e_pce = 1; end
    else if (ph == "D") e_sb = 2'b11;
    else if (ph == "DU") begin e_sb = 2'b11; e_done = 1; end
    else if (ph == "MA") begin e_sa = 1; e_sb = 2'b10; end
    else if (ph == "MR") e_iord = 1;
    else if (ph == "MWB") begin e_m2r = 1; e_rw = 1; e_done = 1; end
    else if (ph == "MW") begin e_iord = 1; e_mw = 1; e_done = 1; end
    else if (ph == "RX") begin e_sa = 1; e_f = alu_for_funct(fn); end
    else if (ph == "RW") begin e_rdst = 1; e_rw = 1; e_done = 1; end
    else if (ph == "BX") begin e_sa = 1; e_f = 3'b110; e_pcs = 2'b01; e_pce = z; e_done = 1; end
    else if (ph == "AX") begin e_sa = 1; e_sb = 2'b10; end
    else if (ph == "AW") begin e_rw = 1; e_done = 1; end
    else if (ph == "JX") begin e_pcs = 2'b10; e_pce = 1; e_done = 1; end
    return {e_iord, e_mw, e_irw, e_rdst, e_m2r, e_rw, e_sa, e_sb, e_pcs, e_pce, e_f, e_done};
  endfunction

  task automatic plan_for(input logic [5:0] opc);
    plan.delete();
    plan.push_back("F");
    case (opc)
      6'b100011: begin plan.push_back("D"); plan.push_back("MA"); plan.push_back("MR"); plan.push_back("MWB"); end
      6'b101011: begin plan.push_back("D"); plan.push_back("MA"); plan.push_back("MW"); end
      6'b000000: begin plan.push_back("D"); plan.push_back("RX"); plan.push_back("RW"); end
      6'b000100: begin plan.push_back("D"); plan.push_back("BX"); end
      6'b001000: begin plan.push_back("D"); plan.push_back("AX"); plan.push_back("AW"); end
      6'b000010: begin plan.push_back("D"); plan.push_back("JX"); end
      default:   plan.push_back("DU");
    endcase
  endtask

  // Entered during a FETCH cycle before its falling edge; leaves just after
  // the rising edge that ends the last executed cycle. zmode 2 = random zero.
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int zmode,
                           input int stop_after, input string tag);
    plan_for(opc);
    op = opc;
    funct = fn;
    for (int i = 0; i < plan.size() && i < stop_after; i++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      @(negedge clk);
      checks++;
      if (state !== state_of(plan[i])) begin
        errors++;
        $display("[TB] FAIL %s state cyc%0d op=%b: got %0d expected %0d", tag, i, opc, state, state_of(plan[i]));
      end
      checks++;
      if (act !== expect_out(plan[i], fn, zero)) begin
        errors++;
        $display("[TB] FAIL %s outputs cyc%0d op=%b funct=%b zero=%b: got %h expected %h",
                 tag, i, opc, fn, zero, act, expect_out(plan[i], fn, zero));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("[TB] FAIL %s state: got %0d expected 0", tag, state);
    end
    checks++;
    if (act !== expect_out("RST", 6'd0, zero)) begin
      errors++;
      $display("[TB] FAIL %s outputs: got %h expected %h", tag, act, expect_out("RST", 6'd0, zero));
    end
  endtask

  task automatic check_first_fetch(input string tag);
    checks++;
    if (state !== 4'd0 || act !== expect_out("F", 6'd0, zero)) begin
      errors++;
      $display("[TB] FAIL %s: got state %0d outputs %h expected state 0 outputs %h",
               tag, state, act, expect_out("F", 6'd0, zero));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op = 6'b100011;
    funct = 6'd0;
    zero = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_reset_vals("reset_hold");
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_first_fetch("reset_release");
  endtask

  task automatic test_midstream_reset();
    run_instr(6'b100011, 6'd0, 2, 3, "mid_lw");
    rst_n = 1'b0;
    zero = 1'b1;
    #1 check_reset_vals("mid_reset_async");
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("mid_reset_hold");
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_first_fetch("mid_reset_release");
  endtask

  task automatic test_lw();
    run_instr(6'b100011, 6'($urandom), 2, 99, "lw");
  endtask

  task automatic test_sw();
    run_instr(6'b101011, 6'($urandom), 2, 99, "sw");
  endtask

  task automatic test_rtype();
    logic [5:0] fns [6];
    fns = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100000, 6'b111111};
    foreach (fns[k]) run_instr(6'b000000, fns[k], 2, 99, "rtype");
  endtask

  task automatic test_beq();
    run_instr(6'b000100, 6'($urandom), 1, 99, "beq_taken");
    run_instr(6'b000100, 6'($urandom), 0, 99, "beq_not_taken");
  endtask

  task automatic test_addi_j();
    run_instr(6'b001000, 6'($urandom), 2, 99, "addi");
    run_instr(6'b000010, 6'($urandom), 2, 99, "j");
  endtask

  task automatic test_unknown();
    run_instr(6'b111111, 6'($urandom), 2, 99, "unknown_3f");
    run_instr(6'b000001, 6'($urandom), 2, 99, "unknown_01");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    logic [5:0] opc;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) opc = 6'($urandom);
      else opc = ops[$urandom_range(0, 5)];
      run_instr(opc, 6'($urandom), 2, 99, "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_addi_j();
    test_unknown();
    test_midstream_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Main sequencing FSM for the multicycle processor. Decodes the instruction opcode/funct held in the instruction register, steps the shared datapath through fetch, decode, execute, memory and writeback cycles, and drives every datapath mux select and write enable. Generates the 3-bit ALU function code `alu_f` for the single shared ALU, which is reused for PC increment, branch-target add, address calculation and execute.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `op`  in  6  instruction[31:26] from IR
- `funct`  in  6  instruction[5:0] from IR
- `zero`  in  1  ALU `Zero` flag
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  data memory write enable
- `ir_write`  out  1  instruction register load
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  writeback select: 0 = ALUOut, 1 = memory data
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A
- `alu_src_b`  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
- `pc_src`  out  2  next PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `pc_en`  out  1  PC load enable
- `alu_f`  out  3  ALU function code
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction
- `state`  out  4  current state, for debug

## Operation
- ALU codes: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- R-type funct decode: 100000→add, 100010→sub, 100100→and, 100101→or, 101010→slt. Any other funct → 010.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE: lw/sw→MEMADR, R→RTYPEEX, beq→BEQEX, addi→ADDIEX, j→JEX. Unknown opcode → FETCH; the instruction executes as a no-op.
  - MEMADR: lw→MEMRD, sw→MEMWR.
  - MEMRD→MEMWB; RTYPEEX→RTYPEWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX → FETCH.
  - Encodings 12–15 → FETCH.
- Moore outputs per state. Any output not listed is 0; `alu_f` defaults to 010.
  - FETCH: alu_src_b=01, ir_write=1, pc_write=1.
  - DECODE: alu_src_b=11.
  - MEMADR: alu_src_a=1, alu_src_b=10.
  - MEMRD: iord=1.
  - MEMWB: mem_to_reg=1, reg_write=1.
  - MEMWR: iord=1, mem_write=1.
  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_f=funct decode.
  - RTYPEWB: reg_dst=1, reg_write=1.
  - BEQEX: alu_src_a=1, alu_f=110, pc_src=01, branch=1.
  - ADDIEX: alu_src_a=1, alu_src_b=10.
  - ADDIWB: reg_write=1.
  - JEX: pc_src=10, pc_write=1.
- `pc_en` = pc_write | (branch & zero), combinational. `pc_write` and `branch` are internal only.
- `instr_done` = 1 in MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX, and in DECODE when the opcode is unknown.

## Timing
- State register updates on the rising edge of `clk`. `rst_n` low forces FETCH immediately, including mid-instruction; the partial instruction is abandoned.
- While `rst_n`=0: mem_write, ir_write, reg_write, pc_en and instr_done are forced to 0. Other outputs take their FETCH values; `state`=0.
- First FETCH cycle is the first rising edge after `rst_n` deasserts.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown 2.
- `op`/`funct` are sampled combinationally from IR, which is stable from DECODE onward.
- `zero` is used only in BEQEX, same cycle (combinational path zero→pc_en).

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-stream, then release → state=0, all write enables 0 during reset; FETCH asserts ir_write=1, pc_en=1, alu_src_b=01, alu_f=010 on the first cycle after release.
- lw (op=100011) → states 0,1,2,3,4. MEMRD has iord=1; MEMWB has reg_write=1, mem_to_reg=1, instr_done=1. Total 5 cycles.
- sw (op=101011) → states 0,1,2,5 with mem_write=1 only in state 5. Total 4 cycles.
- R-type with funct 100010, 100100, 100101, 101010, 100000 → alu_f in RTYPEEX = 110, 000, 001, 111, 010; RTYPEWB has reg_dst=1, reg_write=1.
- beq (op=000100), zero=1 then zero=0 → BEQEX has alu_f=110, pc_src=01, with pc_en=1 and 0 respectively. Total 3 cycles.
- j (op=000010) → JEX has pc_src=10, pc_en=1. Opcode 111111 → DECODE returns to FETCH with instr_done=1 and no write enables asserted.
